// File: rtl/seg7_decode_rx.sv
// Two-digit 7-segment receiver: debounces, decodes and hands off BCD digits.
// Optional binary output bin_o enabled by macro SEG7_DECODE_RX_BIN_EN.
module seg7_decode_rx #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_low_i,
    input  logic [6:0] seg_high_i,
    input  logic       out_ready_i,
    input  logic       err_clr_i,
`ifdef SEG7_DECODE_RX_BIN_EN
    output logic [6:0] bin_o,
`endif
    output logic       out_valid_o,
    output logic [3:0] bcd_low_o,
    output logic [3:0] bcd_high_o,
    output logic       err_o,
    output logic       ovf_o
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);

    // Returns {valid, digit}; patterns are active-low, bit6=g .. bit0=a.
    function automatic logic [4:0] dec(input logic [6:0] p);
        case (p)
            7'b1000000: dec = {1'b1, 4'd0};
            7'b1111001: dec = {1'b1, 4'd1};
            7'b0100100: dec = {1'b1, 4'd2};
            7'b0110000: dec = {1'b1, 4'd3};
            7'b0011001: dec = {1'b1, 4'd4};
            7'b0010010: dec = {1'b1, 4'd5};
            7'b0000010: dec = {1'b1, 4'd6};
            7'b1111000: dec = {1'b1, 4'd7};
            7'b0000000: dec = {1'b1, 4'd8};
            7'b0010000: dec = {1'b1, 4'd9};
            default:    dec = 5'd0;
        endcase
    endfunction

    logic [13:0] sample;
    logic [7:0]  cnt;
    logic [7:0]  last_val;
    logic        have_last;

    logic [13:0] din;
    logic [4:0]  lo_d;
    logic [4:0]  hi_d;
    logic        accept;
    logic        dig_ok;
    logic        is_new;
    logic        load;
    logic        bad;

    assign din    = {seg_high_i, seg_low_i};
    assign lo_d   = dec(sample[6:0]);
    assign hi_d   = dec(sample[13:7]);
    // The counter sits at STABLE_CYCLES-1 for exactly one cycle per stable run.
    assign accept = (cnt == CNT_ACC);
    assign dig_ok = lo_d[4] & hi_d[4];
    assign is_new = !have_last || (last_val != {hi_d[3:0], lo_d[3:0]});
    assign load   = accept & dig_ok & is_new;
    assign bad    = accept & ~dig_ok;

`ifdef SEG7_DECODE_RX_BIN_EN
    logic [6:0] bin_nxt;
    assign bin_nxt = {3'b000, hi_d[3:0]} * 7'd10 + {3'b000, lo_d[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bin_o <= 7'd0;
        else if (load)
            bin_o <= bin_nxt;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample      <= 14'h3FFF;
            cnt         <= 8'd0;
            last_val    <= 8'd0;
            have_last   <= 1'b0;
            out_valid_o <= 1'b0;
            bcd_low_o   <= 4'd0;
            bcd_high_o  <= 4'd0;
            err_o       <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            sample <= din;
            if (din != sample)
                cnt <= 8'd0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;

            if (load) begin
                bcd_low_o   <= lo_d[3:0];
                bcd_high_o  <= hi_d[3:0];
                last_val    <= {hi_d[3:0], lo_d[3:0]};
                have_last   <= 1'b1;
                out_valid_o <= 1'b1;
                if (out_valid_o && !out_ready_i)
                    ovf_o <= 1'b1;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            if (bad)
                err_o <= 1'b1;
            else if (err_clr_i)
                err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_decode_rx.sv
// Randomized bench for seg7_decode_rx against a run-length reference model.
// Define SEG7_DECODE_RX_BIN_EN to also exercise bin_o.
module tb_seg7_decode_rx;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_low;
    logic [6:0] seg_high;
    logic       out_ready;
    logic       err_clr;
    logic       out_valid;
    logic [3:0] bcd_low;
    logic [3:0] bcd_high;
    logic       err;
    logic       ovf;
`ifdef SEG7_DECODE_RX_BIN_EN
    logic [6:0] bin;
`endif

    seg7_decode_rx #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_low_i  (seg_low),
        .seg_high_i (seg_high),
        .out_ready_i(out_ready),
        .err_clr_i  (err_clr),
`ifdef SEG7_DECODE_RX_BIN_EN
        .bin_o      (bin),
`endif
        .out_valid_o(out_valid),
        .bcd_low_o  (bcd_low),
        .bcd_high_o (bcd_high),
        .err_o      (err),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: history of captured input pairs plus output state.
    logic [13:0] hist [$];
    bit          m_valid, m_err, m_ovf, m_have;
    int          m_last, m_lo, m_hi;

    function automatic int seg2dig(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(14'h3FFF);
        m_valid = 0; m_err = 0; m_ovf = 0; m_have = 0;
        m_last = 0; m_lo = 0; m_hi = 0;
    endtask

    // A pair is accepted when it has been the captured value for exactly
    // S consecutive edges; its outputs appear on the following edge.
    task automatic model_edge();
        int run = 0;
        int dh, dl, val;
        bit acc, ok, fresh;
        logic [13:0] v = hist[hist.size() - 1];
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != v) break;
            run++;
        end
        hist.push_back({seg_high, seg_low});
        if (hist.size() > 64) void'(hist.pop_front());
        dh    = seg2dig(v[13:7]);
        dl    = seg2dig(v[6:0]);
        acc   = (run == S);
        ok    = (dh >= 0) && (dl >= 0);
        val   = dh * 10 + dl;
        fresh = ok && (!m_have || m_last != val);
        if (acc && !ok) m_err = 1;
        else if (err_clr) m_err = 0;
        if (acc && fresh) begin
            if (m_valid && !out_ready) m_ovf = 1;
            m_valid = 1; m_hi = dh; m_lo = dl;
            m_last = val; m_have = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, m_valid);
        check("bcd_low", bcd_low, m_lo);
        check("bcd_high", bcd_high, m_hi);
        check("err", err, m_err);
        check("ovf", ovf, m_ovf);
`ifdef SEG7_DECODE_RX_BIN_EN
        check("bin", bin, m_hi * 10 + m_lo);
`endif
    endtask

    // Called at a negedge with inputs already driven.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        err_clr = 1'b0;
    endtask

    task automatic set_pair(input int h, input int l);
        seg_high = seg_tab[h];
        seg_low  = seg_tab[l];
    endtask

    task automatic hold(input int h, input int l, input int n);
        set_pair(h, l);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_bcd", {bcd_high, bcd_low}, 8'd0);
        check("rst_flags", {err, ovf}, 2'b00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; err_clr = 1'b0;
        set_pair(0, 0);
        @(negedge clk);
        do_reset();

        // Held 25 appears after the fifth edge counting the capture edge.
        set_pair(2, 5);
        repeat (4) tick();
        check("s28_early", out_valid, 1'b0);
        tick();
        check("s28_valid", out_valid, 1'b1);
        check("s28_bcd", {bcd_high, bcd_low}, 8'h25);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("s28_taken", out_valid, 1'b0);

        // Fast toggling never qualifies.
        for (int i = 0; i < 10; i++)
            hold(0, (i % 2 == 0) ? 1 : 2, 2);
        check("s29_valid", out_valid, 1'b0);
        check("s29_err", err, 1'b0);

        // Blank ones digit raises err.
        seg_high = seg_tab[1];
        seg_low  = 7'h7F;
        repeat (6) tick();
        check("s30_err", err, 1'b1);
        check("s30_valid", out_valid, 1'b0);
        hold(4, 4, 1);
        err_clr = 1'b1;
        tick();
        check("s30_clr", err, 1'b0);

        // Overrun while consumer stalls.
        hold(1, 2, 6);
        hold(3, 4, 6);
        check("s31_bcd", {bcd_high, bcd_low}, 8'h34);
        check("s31_valid", out_valid, 1'b1);
        check("s31_ovf", ovf, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("s31_taken", out_valid, 1'b0);

        // Repeat of the last accepted value is ignored.
        hold(0, 7, 6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        hold(0, 8, 1);
        hold(0, 7, 8);
        check("s32_norepeat", out_valid, 1'b0);

        // Reset mid-count with data pending, then re-qualification.
        hold(5, 6, 6);
        check("s33_pending", out_valid, 1'b1);
        hold(9, 1, 3);
        do_reset();
        repeat (S) tick();
        check("s33_early", out_valid, 1'b0);
        tick();
        check("s33_valid", out_valid, 1'b1);
        check("s33_bcd", {bcd_high, bcd_low}, 8'h91);

        // Random traffic.
        repeat (200) begin
            int n = $urandom_range(1, 7);
            set_pair($urandom_range(0, 9), $urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) seg_low = 7'($urandom);
            repeat (n) begin
                out_ready = 1'($urandom);
                err_clr   = ($urandom_range(0, 7) == 0);
                tick();
            end
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
